// File: rtl/demux_1x4_pipe_pkg.sv
// Shared lane count, select width and lane index constants for the 1:4 registered demux.
package demux_1x4_pipe_pkg;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned SEL_W     = 2;

    localparam logic [SEL_W-1:0] LANE0 = SEL_W'(0);
    localparam logic [SEL_W-1:0] LANE1 = SEL_W'(1);
    localparam logic [SEL_W-1:0] LANE2 = SEL_W'(2);
    localparam logic [SEL_W-1:0] LANE3 = SEL_W'(3);

    // One-hot lane mask for a select value.
    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [SEL_W-1:0] sel);
        return NUM_LANES'(1) << sel;
    endfunction

endpackage

// File: rtl/demux_lane_reg.sv
// One-entry valid/ready pipeline register; drain and refill on the same edge keep valid high.
module demux_lane_reg #(
    parameter int unsigned LEN = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           load,
    input  logic [LEN-1:0] d,
    output logic           valid,
    input  logic           ready,
    output logic [LEN-1:0] q,
    output logic           can_acc
);

    // Space is available when empty or when the held word leaves this cycle.
    assign can_acc = ~valid | ready;

    // Data only moves on load; a drain leaves the stale word behind with valid low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1x4_pipe.sv
// Registered 1:4 demultiplexer with per-lane valid/ready and 1-cycle latency.
// Define DEMUX_BCAST_EN to add the in_bcast port (load one word into all four lanes).
module demux_1x4_pipe
    import demux_1x4_pipe_pkg::*;
#(
    parameter int unsigned LEN = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [LEN-1:0]       in_data,
    output logic [NUM_LANES-1:0] out_valid,
    input  logic [NUM_LANES-1:0] out_ready,
    output logic [LEN-1:0]       out0,
    output logic [LEN-1:0]       out1,
    output logic [LEN-1:0]       out2,
    output logic [LEN-1:0]       out3
`ifdef DEMUX_BCAST_EN
    ,
    input  logic                 in_bcast
`endif
);

    logic [NUM_LANES-1:0] can_acc;
    logic [NUM_LANES-1:0] sel_mask;
    logic [NUM_LANES-1:0] load;
    logic [LEN-1:0]       lane_q [NUM_LANES];
    logic                 bcast;

`ifdef DEMUX_BCAST_EN
    assign bcast = in_bcast;
`else
    assign bcast = 1'b0;
`endif

    // in_ready depends only on select, lane state and consumer ready, never on in_valid.
    always_comb begin
        sel_mask = lane_onehot(in_sel);
        in_ready = can_acc[in_sel];
        if (bcast) begin
            sel_mask = '1;
            in_ready = &can_acc;
        end
        load = {NUM_LANES{in_valid & in_ready}} & sel_mask;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        demux_lane_reg #(
            .LEN(LEN)
        ) u_lane (
            .clk    (clk),
            .reset_n(reset_n),
            .load   (load[i]),
            .d      (in_data),
            .valid  (out_valid[i]),
            .ready  (out_ready[i]),
            .q      (lane_q[i]),
            .can_acc(can_acc[i])
        );
    end

    assign out0 = lane_q[LANE0];
    assign out1 = lane_q[LANE1];
    assign out2 = lane_q[LANE2];
    assign out3 = lane_q[LANE3];

endmodule

// File: tb/tb_demux_1x4_pipe.sv
// Scoreboard bench for demux_1x4_pipe: per-lane expected-word queues fed by the driver, checked by a monitor.
module tb_demux_1x4_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_sel;
    logic [7:0] in_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out0, out1, out2, out3;
    logic       in_bcast;
    logic [7:0] outs [4];

    logic [7:0] exp_q [4][$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux_1x4_pipe #(.LEN(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3)
`ifdef DEMUX_BCAST_EN
        ,
        .in_bcast (in_bcast)
`endif
    );

    always_comb begin
        outs[0] = out0;
        outs[1] = out1;
        outs[2] = out2;
        outs[3] = out3;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each lane must present exactly the head of its queue; a word leaves when its consumer is ready.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                logic ev;
                ev = (exp_q[i].size() != 0);
                chk($sformatf("out_valid[%0d]", i), 32'(out_valid[i]), 32'(ev));
                if (ev) begin
                    chk($sformatf("out%0d_data", i), 32'(outs[i]), 32'(exp_q[i][0]));
                    if (out_ready[i]) void'(exp_q[i].pop_front());
                end
            end
        end
    end

    // One cycle: drive after the edge, then (after the monitor has retired outgoing words)
    // a lane can accept exactly when its queue is empty.
    task automatic cyc(input logic v, input logic [1:0] s, input logic [7:0] d,
                       input logic [3:0] r, input logic b, output logic acc);
        logic exp_rdy;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = r;
        in_bcast  = b;
        @(negedge clk);
        #1;
        if (b)
            exp_rdy = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) &&
                      (exp_q[2].size() == 0) && (exp_q[3].size() == 0);
        else
            exp_rdy = (exp_q[s].size() == 0);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        if (acc) begin
            if (b) for (int i = 0; i < 4; i++) exp_q[i].push_back(d);
            else   exp_q[s].push_back(d);
        end
    endtask

    initial begin
        logic       acc;
        logic       pv;
        logic [1:0] ps;
        logic [7:0] pd;
        logic       pending;

        // Reset held with a request pending: nothing captured, in_ready still high.
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 2'd2;
        in_data   = 8'h77;
        out_ready = 4'hF;
        in_bcast  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out0", 32'(out0), 32'h0);
        chk("rst_out1", 32'(out1), 32'h0);
        chk("rst_out2", 32'(out2), 32'h0);
        chk("rst_out3", 32'(out3), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'h1);
        exp_q[2].push_back(8'h77);

        // Unicast sweep across lanes.
        for (int i = 0; i < 4; i++) cyc(1'b1, 2'(i), 8'(8'hA0 + i), 4'hF, 1'b0, acc);
        cyc(1'b0, 2'd0, 8'h00, 4'hF, 1'b0, acc);

        // Back-pressure on lane 1 while lane 3 keeps moving.
        cyc(1'b1, 2'd1, 8'h11, 4'b1101, 1'b0, acc);
        cyc(1'b1, 2'd3, 8'h33, 4'b1101, 1'b0, acc);
        cyc(1'b1, 2'd1, 8'h22, 4'b1101, 1'b0, acc);
        cyc(1'b1, 2'd1, 8'h22, 4'b1101, 1'b0, acc);
        cyc(1'b1, 2'd1, 8'h22, 4'b1111, 1'b0, acc);
        chk("bp_refill_acc", 32'(acc), 32'h1);
        cyc(1'b0, 2'd0, 8'h00, 4'hF, 1'b0, acc);

        // Streaming into lane 2.
        for (int i = 0; i < 16; i++) cyc(1'b1, 2'd2, 8'(i), 4'hF, 1'b0, acc);
        cyc(1'b0, 2'd0, 8'h00, 4'hF, 1'b0, acc);

        // Async reset between edges with lanes 0 and 3 holding words.
        cyc(1'b1, 2'd0, 8'h10, 4'h0, 1'b0, acc);
        cyc(1'b1, 2'd3, 8'h13, 4'h0, 1'b0, acc);
        cyc(1'b0, 2'd0, 8'h00, 4'h0, 1'b0, acc);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_out0", 32'(out0), 32'h0);
        chk("mid_rst_out3", 32'(out3), 32'h0);
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        #1 reset_n = 1'b1;

`ifdef DEMUX_BCAST_EN
        cyc(1'b1, 2'd1, 8'h5A, 4'hF, 1'b1, acc);
        cyc(1'b0, 2'd0, 8'h00, 4'hF, 1'b0, acc);
        cyc(1'b1, 2'd2, 8'h42, 4'b1011, 1'b0, acc);
        cyc(1'b1, 2'd0, 8'hC3, 4'b1011, 1'b1, acc);
        cyc(1'b1, 2'd0, 8'hC3, 4'b1011, 1'b1, acc);
        cyc(1'b1, 2'd0, 8'hC3, 4'b1111, 1'b1, acc);
        cyc(1'b0, 2'd0, 8'h00, 4'hF, 1'b0, acc);
`endif

        // Random traffic; a stalled request is held stable until accepted.
        pending = 1'b0;
        pv = 1'b0;
        ps = 2'd0;
        pd = 8'h00;
        repeat (300) begin
            if (!pending) begin
                pv = ($urandom_range(0, 3) != 0);
                ps = 2'($urandom_range(0, 3));
                pd = 8'($urandom);
            end
            cyc(pv, ps, pd, 4'($urandom) | 4'($urandom), 1'b0, acc);
            pending = pv && !acc;
        end
        if (pending) cyc(pv, ps, pd, 4'hF, 1'b0, acc);

        repeat (3) cyc(1'b0, 2'd0, 8'h00, 4'hF, 1'b0, acc);
        for (int i = 0; i < 4; i++) chk($sformatf("drained[%0d]", i), 32'(exp_q[i].size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_1x4_pipe.md
Name: demux_1x4_pipe

Overview:
- Registered 1-to-4 demultiplexer with valid/ready handshake on every side.
- One input stream carries a 2-bit lane select with each word. Each word is steered into a one-entry output register on the selected lane.
- It is the distribution-side counterpart of the 4:1 select muxes in the datapath. It fans a shared bus (memory read-out, bus interface) out to four PE/PU consumers.
- Full throughput per lane, fixed 1-cycle latency.

Parameters:
- LEN, 8, data word width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  selected lane can accept this cycle.
- in_sel  input  2  destination lane (0..3); qualified by in_valid.
- in_data  input  LEN  input word.
- out_valid  output  4  bit i: lane i register holds a word.
- out_ready  input  4  bit i: lane i consumer accepts.
- out0, out1, out2, out3  output  LEN each  lane data registers.
- in_bcast  input  1  broadcast request (only with DEMUX_BCAST_EN).

Behaviour:
- Reset (reset_n low, async):
  - valid_q[3:0] = 0.
  - out0..out3 = 0.
  - in_ready follows the combinational rule below, so it reads 1 during reset.
- Per lane i: can_acc[i] = ~valid_q[i] | out_ready[i].
- in_ready = can_acc[in_sel]. It is combinational from in_sel, valid_q and out_ready. It is never derived from in_valid, so there is no combinational in_valid->in_ready path.
- Input transfer occurs when in_valid & in_ready. On that clk edge:
  - lane in_sel captures in_data;
  - valid_q[in_sel] is set to 1.
- Output transfer on lane i occurs when out_valid[i] & out_ready[i]. On that edge valid_q[i] clears, unless the same edge refills the lane.
- Simultaneous drain and refill of one lane: the new word is loaded and valid stays 1. There is no bubble, giving 1 word/cycle/lane.
- Latency: a word accepted at edge N is visible on out<sel> with out_valid high after edge N.
- Hold rule: while out_valid[i] & ~out_ready[i], out<i> and out_valid[i] are stable.
- Lane independence:
  - a stalled lane blocks input only while in_sel points at it;
  - other lanes keep draining;
  - order within a lane is preserved;
  - there is no ordering across lanes.
- Source requirement: in_sel and in_data are stable while in_valid & ~in_ready.
- Data registers load only on accept. They are not cleared on drain; stale data remains with out_valid=0.
- Reset mid-operation: all buffered words are discarded, valid_q clears immediately (async), and data registers go to 0.

Optional Feature:
- Macro: DEMUX_BCAST_EN.
- Defined:
  - the in_bcast port exists;
  - when in_bcast=1, in_ready = &can_acc, i.e. all four lanes must be able to accept;
  - the accepted word is loaded into all four lanes and all valid_q bits are set;
  - in_sel is ignored while in_bcast=1;
  - with in_bcast=0, behaviour is as above.
- Undefined:
  - the in_bcast port is absent;
  - unicast only.

Decomposition:
- Shared package/header holds:
  - NUM_LANES = 4;
  - SEL_W = 2;
  - lane index constants LANE0..LANE3.
- Natural sub-module: demux_lane_reg, a one-entry valid/ready pipeline register. It has the following ports:
  - clk, reset_n;
  - load, d;
  - valid, ready, q;
  - can_acc output.
- Top level: four demux_lane_reg instances plus select decode and in_ready mux.

Test Plan:
- Reset: hold reset_n low with in_valid=1 and in_sel=2 -> out_valid=4'b0000, out0..3=0, and nothing is captured. Release reset -> first accept happens at the next edge.
- Unicast sweep: out_ready=4'b1111; send 0xA0,0xA1,0xA2,0xA3 with sel 0,1,2,3 on consecutive cycles -> each appears on out<sel> one cycle later, out_valid is one-hot per cycle, and in_ready stays 1.
- Back-pressure: out_ready[1]=0. Send 0x11 then 0x22 to lane 1 -> 0x11 is held on out1 and in_ready=0 for the second word. Meanwhile send 0x33 to lane 3 -> accepted. Raise out_ready[1] -> 0x22 replaces 0x11 on the same edge with no bubble.
- Streaming: 16 back-to-back words to lane 2 (0x00..0x0F) with out_ready[2]=1 -> out_valid[2] is continuously 1 and the words arrive in order at 1/cycle.
- Async reset mid-stream: lanes 0 and 3 loaded; pulse reset_n low between edges -> out_valid clears immediately and out0/out3=0.
- DEMUX_BCAST_EN:
  - in_bcast=1, data 0x5A, all lanes ready -> all four outputs = 0x5A with out_valid=4'b1111;
  - repeat with out_ready[2]=0 while lane 2 is full -> in_ready=0 and no lane loads.
